// File: rtl/keyboard_scanner.sv
// Key-to-note front end: synchronises and debounces the key and octave inputs, then
// resolves simultaneous presses by MODE into a registered note index with on/off pulses.
module keyboard_scanner #(
  parameter int NUM_KEYS        = 7,
  parameter int NUM_OCTAVES     = 3,
  parameter int DEFAULT_OCTAVE  = 1,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int MODE            = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic [4:0]          note,
  output logic                note_on,
  output logic                note_off,
  output logic [3:0]          octave,
  output logic [NUM_KEYS-1:0] key_stable
);

  localparam int NI = NUM_KEYS + 2;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 15) begin : g_bad_keys
      $error("keyboard_scanner: NUM_KEYS must be 1..15");
    end
    if (NUM_OCTAVES < 1 || NUM_OCTAVES * NUM_KEYS > 31) begin : g_bad_octaves
      $error("keyboard_scanner: NUM_OCTAVES*NUM_KEYS must not exceed 31");
    end
    if (DEFAULT_OCTAVE < 0 || DEFAULT_OCTAVE >= NUM_OCTAVES) begin : g_bad_default
      $error("keyboard_scanner: DEFAULT_OCTAVE out of range");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("keyboard_scanner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("keyboard_scanner: MODE must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE,
    ST_PLAYING
  } state_t;

  // Bit layout shared by all per-input stages: keys low, then oct_up, then oct_down.
  logic [NI-1:0] raw_in;
  logic [NI-1:0] sync1_q, sync2_q;
  logic [NI-1:0] stable_q, stable_d;
  logic [NI-1:0] rise;

  assign raw_in = {oct_down, oct_up, key};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_debounce
      logic [CW-1:0] cnt_q, cnt_d;
      logic          differs;

      assign differs = (sync2_q[gi] != stable_q[gi]);
      // The counter holds how many consecutive samples already disagreed; the
      // sample that would make it DEBOUNCE_CYCLES commits the new level instead.
      assign stable_d[gi] = (differs && cnt_q == CNT_LAST) ? sync2_q[gi] : stable_q[gi];
      assign cnt_d = (!differs || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign rise = stable_d & ~stable_q;

  logic [NUM_KEYS-1:0] key_st;
  logic [NUM_KEYS-1:0] key_rise;
  logic                up_rise, down_rise;

  assign key_st    = stable_q[NUM_KEYS-1:0];
  assign key_rise  = rise[NUM_KEYS-1:0];
  assign up_rise   = rise[NUM_KEYS];
  assign down_rise = rise[NUM_KEYS+1];

  logic [3:0] octave_q, octave_d;

  always_comb begin
    octave_d = octave_q;
    if (up_rise && !down_rise && octave_q != 4'(NUM_OCTAVES - 1)) begin
      octave_d = octave_q + 4'd1;
    end else if (down_rise && !up_rise && octave_q != 4'd0) begin
      octave_d = octave_q - 4'd1;
    end
  end

  logic [IW-1:0] last_idx_q, last_idx_d;

  // Updated on the same edge the key becomes debounced, so selection sees both together.
  always_comb begin
    last_idx_d = last_idx_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_rise[i]) last_idx_d = IW'(i);
    end
  end

  logic [IW-1:0] lowest_idx;
  logic          any_key;
  logic          one_hot;

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_st[i]) lowest_idx = IW'(i);
    end
  end

  assign any_key = |key_st;
  assign one_hot = any_key && ((key_st & (key_st - 1'b1)) == '0);

  logic [IW-1:0] sel_idx;
  logic          sel_valid;

  always_comb begin
    sel_idx   = lowest_idx;
    sel_valid = 1'b0;
    case (MODE)
      0: sel_valid = one_hot;
      1: sel_valid = any_key;
      default: begin
        sel_valid = any_key;
        if (key_st[last_idx_q]) sel_idx = last_idx_q;
      end
    endcase
  end

  logic [4:0] note_q, note_d;
  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  state_t     state_q, state_d;
  int         note_val;

  always_comb begin
    note_val   = 1 + int'(octave_q) * NUM_KEYS + int'(sel_idx);
    note_d     = sel_valid ? 5'(note_val) : 5'd0;
    note_on_d  = (note_d != note_q) && (note_d != 5'd0);
    note_off_d = (state_q == ST_PLAYING) && (note_d == 5'd0);
  end

  // PLAYING mirrors note != 0; retargets keep it PLAYING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (note_on_d)  state_d = ST_PLAYING;
      ST_PLAYING: if (note_off_d) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q   <= '0;
      octave_q   <= 4'(DEFAULT_OCTAVE);
      last_idx_q <= '0;
      note_q     <= '0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      stable_q   <= stable_d;
      octave_q   <= octave_d;
      last_idx_q <= last_idx_d;
      note_q     <= note_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      state_q    <= state_d;
    end
  end

  assign note       = note_q;
  assign note_on    = note_on_q;
  assign note_off   = note_off_q;
  assign octave     = octave_q;
  assign key_stable = key_st;

endmodule
